i2c_scl_master_gen: RTL and testbench
=====================================

// Module: i2c_scl_master_gen
// PURPOSE
//  Parametrised open-drain I2C SCL generator for the iic_controll master path.
//  Separate, programmable low/high phase lengths; clock stretching detection with timeout;
//  multi-master clock synchronisation. One-cycle phase strobes let the SDA/byte FSM
//  change data at low-midpoint and sample at high-midpoint.
// PARAMETERS
//  DIV_W       16  width of div_lo/div_hi phase counters (clk cycles)
//  STO_W       20  width of stretch timeout counter
//  SYNC_STAGES 2   scl_in synchroniser depth (>=2)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  en           in   1      run request (level); clock runs while high
//  div_lo       in   DIV_W  SCL low phase length, clk cycles (values <4 treated as 4)
//  div_hi       in   DIV_W  SCL high phase length, clk cycles (values <4 treated as 4)
//  stretch_to   in   STO_W  max cycles waiting for SCL high after release; 0 = no timeout
//  scl_in       in   1      raw SCL pad level (async)
//  scl_oe       out  1      1 = drive SCL low, 0 = release (pad pulled up)
//  busy         out  1      state != IDLE
//  stretching   out  1      SCL held low externally beyond synchroniser latency
//  tick_fall    out  1      pulse: first cycle scl_oe=1 of each LOW phase
//  tick_lo_mid  out  1      pulse: LOW count == div_lo/2 (SDA change point)
//  tick_rise    out  1      pulse: first cycle of HIGH phase (SCL seen high)
//  tick_hi_mid  out  1      pulse: HIGH count == div_hi/2 (SDA sample point)
//  timeout      out  1      pulse: stretch timeout fired
// BEHAVIOUR
//  Reset: state=IDLE, scl_oe=0, all pulses/busy/stretching=0, counters=0, armed=1, sync chain=1.
//  All outputs registered. rst is synchronous: asserted mid-run, scl_oe=0 from next edge.
//  Divider values latched into shadow regs on every LOW entry; mid-phase changes apply next period.
//  States:
//   IDLE: scl_oe=0. en=1 & armed -> LOW (tick_fall). en=0 sets armed=1.
//   LOW: scl_oe=1, cnt 0..lo-1; tick_lo_mid at cnt==lo>>1; at cnt==lo-1 -> RELEASE.
//   RELEASE: scl_oe=0, scnt counts from 0. scl_sync=1 -> HIGH (tick_rise), scnt=0.
//    stretching=1 while scnt>=SYNC_STAGES+1. stretch_to!=0 & scnt==stretch_to-1 ->
//    timeout pulse, armed=0, -> IDLE (en must go low before restart).
//   HIGH: scl_oe=0, cnt 0..hi-1; tick_hi_mid at cnt==hi>>1.
//    cnt==hi-1: en=1 -> LOW (tick_fall) else -> IDLE (SCL left released).
//    scl_sync=0 before cnt==hi-1 (other master) -> LOW immediately, cnt=0, tick_fall;
//    checked from cnt>=1 only, and overrides tick_hi_mid in that cycle.
//  en=0 anywhere in a period: period completes (LOW,RELEASE,HIGH), then IDLE; no truncation.
//  Nominal period, no stretch, pad follows scl_oe: lo + hi + SYNC_STAGES + 1 cycles.
//  Counters saturate never: cnt cleared on every state entry, width DIV_W, no wrap possible.
//  Only one tick_* asserted per cycle; timeout and tick_rise mutually exclusive (sync wins).
// TESTING
//  1 loopback scl_in=~scl_oe, lo=8 hi=8, en=1 -> period 19 clk, tick order fall,lo_mid(+4),
//    rise,hi_mid(+4); scl_oe low exactly 8 cycles per period.
//  2 slave holds scl_in low 50 cycles past release -> stretching=1 after 3 cycles, HIGH
//    starts 3 cycles after pad high, period 69; no timeout with stretch_to=0.
//  3 stretch_to=100, scl_in stuck low -> timeout pulse 100 cycles into RELEASE, busy=0,
//    scl_oe=0; en kept high -> stays IDLE; en 0->1 -> new tick_fall.
//  4 en dropped at LOW cnt=2 -> one tick_rise, one tick_hi_mid, then IDLE, scl_oe=0, busy=0.
//  5 external pull-low at HIGH cnt=3 (hi=8) -> tick_fall and scl_oe=1 within 3 cycles,
//    full 8-cycle LOW follows; no tick_hi_mid that period.
//  6 lo=2 hi=1 -> phases of 4; rst pulse at LOW cnt=2 -> scl_oe=0, busy=0 next edge.

Source files
------------

// File: rtl/i2c_scl_master_gen.sv
// i2c_scl_master_gen: open-drain I2C SCL generator with stretching, timeout and multi-master sync
module i2c_scl_master_gen #(
  parameter int DIV_W       = 16,
  parameter int STO_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_lo_i,
  input  logic [DIV_W-1:0] div_hi_i,
  input  logic [STO_W-1:0] stretch_to_i,
  input  logic             scl_in_i,
  output logic             scl_oe_o,
  output logic             busy_o,
  output logic             stretching_o,
  output logic             tick_fall_o,
  output logic             tick_lo_mid_o,
  output logic             tick_rise_o,
  output logic             tick_hi_mid_o,
  output logic             timeout_o
);
  typedef enum logic [1:0] {IDLE, LOW, RELEASE, HIGH} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DIV_W-1:0] cnt_q, cnt_d, lo_q, lo_d, hi_q, hi_d;
  logic [STO_W-1:0] scnt_q, scnt_d;
  logic armed_q, armed_d, fall, rise, to_d;
  logic scl_oe_q, busy_q, stretching_q, tick_fall_q, tick_lo_mid_q, tick_rise_q, tick_hi_mid_q, timeout_q;
  wire scl_sync = sync_q[SYNC_STAGES-1];
  function automatic logic [DIV_W-1:0] clamp4(input logic [DIV_W-1:0] v);
    return v < DIV_W'(4) ? DIV_W'(4) : v;
  endfunction
  // pad synchroniser, idles high like the pulled-up bus
  always_ff @(posedge clk)
    if (rst) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], scl_in_i};
  // FSM state, counters, phase-length shadows
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      scnt_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      scnt_q <= scnt_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      armed_q <= armed_d;
    end
  // next-state logic; a local SCL low seen during HIGH means another master pulled the clock
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    fall = 1'b0;
    rise = 1'b0;
    to_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!en_i) armed_d = 1'b1;
        else if (armed_q) begin
          state_d = LOW;
          fall = 1'b1;
        end
      end
      LOW: state_d = cnt_q == lo_q - DIV_W'(1) ? RELEASE : LOW;
      RELEASE: begin
        if (scl_sync) begin
          state_d = HIGH;
          rise = 1'b1;
        end else if (stretch_to_i != '0 && scnt_q == stretch_to_i - STO_W'(1)) begin
          state_d = IDLE;
          to_d = 1'b1;
          armed_d = 1'b0;
        end
      end
      HIGH: begin
        if (cnt_q == hi_q - DIV_W'(1)) begin
          state_d = en_i ? LOW : IDLE;
          fall = en_i;
        end else if (cnt_q != '0 && !scl_sync) begin
          state_d = LOW;
          fall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q || state_d == IDLE ? '0 : cnt_q + DIV_W'(1);
    scnt_d = state_q == RELEASE && state_d == RELEASE ? scnt_q + STO_W'(~&scnt_q) : '0;
    lo_d = fall ? clamp4(div_lo_i) : lo_q;
    hi_d = fall ? clamp4(div_hi_i) : hi_q;
  end
  // registered outputs derived from the upcoming state so they align with it
  always_ff @(posedge clk)
    if (rst) begin
      scl_oe_q <= 1'b0;
      busy_q <= 1'b0;
      stretching_q <= 1'b0;
      tick_fall_q <= 1'b0;
      tick_lo_mid_q <= 1'b0;
      tick_rise_q <= 1'b0;
      tick_hi_mid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      scl_oe_q <= state_d == LOW;
      busy_q <= state_d != IDLE;
      stretching_q <= state_d == RELEASE && scnt_d >= STO_W'(SYNC_STAGES + 1);
      tick_fall_q <= fall;
      tick_lo_mid_q <= state_d == LOW && cnt_d == (lo_d >> 1);
      tick_rise_q <= rise;
      tick_hi_mid_q <= state_d == HIGH && cnt_d == (hi_d >> 1);
      timeout_q <= to_d;
    end
  assign scl_oe_o = scl_oe_q;
  assign busy_o = busy_q;
  assign stretching_o = stretching_q;
  assign tick_fall_o = tick_fall_q;
  assign tick_lo_mid_o = tick_lo_mid_q;
  assign tick_rise_o = tick_rise_q;
  assign tick_hi_mid_o = tick_hi_mid_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_i2c_scl_master_gen.sv
// tb_i2c_scl_master_gen: directed checks of SCL timing, stretching, timeout, sync and reset
module tb_i2c_scl_master_gen;
  localparam int FALL = 0, LO_MID = 1, RISE = 2, HI_MID = 3, TMO = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, hold = 1'b0, ext = 1'b0;
  logic [15:0] div_lo = 16'd8, div_hi = 16'd8;
  logic [19:0] stretch_to = '0;
  logic scl_oe, busy, stretching, tick_fall, tick_lo_mid, tick_rise, tick_hi_mid, timeout;
  int checks = 0, errors = 0;
  int n_fall = 0, n_rise = 0, n_himid = 0, n_to = 0, n_multi = 0;
  wire scl_in = ~scl_oe & ~hold & ~ext;
  i2c_scl_master_gen dut (
    .clk(clk), .rst(rst), .en_i(en), .div_lo_i(div_lo), .div_hi_i(div_hi),
    .stretch_to_i(stretch_to), .scl_in_i(scl_in), .scl_oe_o(scl_oe), .busy_o(busy),
    .stretching_o(stretching), .tick_fall_o(tick_fall), .tick_lo_mid_o(tick_lo_mid),
    .tick_rise_o(tick_rise), .tick_hi_mid_o(tick_hi_mid), .timeout_o(timeout)
  );
  always #5 clk = ~clk;
  // running pulse tallies plus a count of cycles with more than one pulse
  always @(posedge clk) begin
    n_fall <= n_fall + int'(tick_fall);
    n_rise <= n_rise + int'(tick_rise);
    n_himid <= n_himid + int'(tick_hi_mid);
    n_to <= n_to + int'(timeout);
    if (int'(tick_fall) + int'(tick_lo_mid) + int'(tick_rise) + int'(tick_hi_mid) + int'(timeout) > 1)
      n_multi <= n_multi + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic sel(input int w);
    return w == FALL ? tick_fall : w == LO_MID ? tick_lo_mid : w == RISE ? tick_rise :
           w == HI_MID ? tick_hi_mid : timeout;
  endfunction
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_tick(input string tag, input int w, input int exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel(w) && n < 300);
    check({tag, "_seen"}, sel(w), 1);
    check(tag, n, exp);
  endtask
  initial begin
    int n, oe, f0, r0, h0;
    step(3);
    check("rst_oe", scl_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_stretch", stretching, 0);
    check("rst_ticks", {tick_fall, tick_lo_mid, tick_rise, tick_hi_mid, timeout}, 0);
    rst = 1'b0;
    step(1);
    en = 1'b1;
    wait_tick("t1_first_fall", FALL, 1);
    check("t1_oe_at_fall", scl_oe, 1);
    wait_tick("t1_lo_mid", LO_MID, 4);
    wait_tick("t1_rise", RISE, 7);
    wait_tick("t1_hi_mid", HI_MID, 4);
    wait_tick("t1_next_fall", FALL, 4);
    n = 0;
    oe = 1;
    do begin
      @(negedge clk);
      n++;
      if (!tick_fall) oe += int'(scl_oe);
    end while (!tick_fall && n < 300);
    check("t1_period", n, 19);
    check("t1_oe_low_cycles", oe, 8);
    hold = 1'b1;
    step(8);
    check("t2_released", scl_oe, 0);
    step(2);
    check("t2_stretch_early", stretching, 0);
    step(1);
    check("t2_stretch_on", stretching, 1);
    step(47);
    hold = 1'b0;
    wait_tick("t2_rise_after_pad", RISE, 3);
    check("t2_stretch_off", stretching, 0);
    wait_tick("t2_fall", FALL, 8);
    check("t2_no_timeout", n_to, 0);
    stretch_to = 20'd100;
    hold = 1'b1;
    wait_tick("t3_timeout", TMO, 108);
    check("t3_busy", busy, 0);
    check("t3_oe", scl_oe, 0);
    hold = 1'b0;
    f0 = n_fall;
    step(20);
    check("t3_stays_idle", busy, 0);
    check("t3_no_restart", n_fall - f0, 0);
    en = 1'b0;
    stretch_to = '0;
    step(1);
    en = 1'b1;
    wait_tick("t3_restart", FALL, 1);
    step(2);
    en = 1'b0;
    f0 = n_fall;
    r0 = n_rise;
    h0 = n_himid;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    check("t4_idle_after", n, 17);
    step(1);
    check("t4_rises", n_rise - r0, 1);
    check("t4_himids", n_himid - h0, 1);
    check("t4_falls", n_fall - f0, 0);
    check("t4_oe", scl_oe, 0);
    check("t4_busy", busy, 0);
    en = 1'b1;
    wait_tick("t5_fall", FALL, 1);
    wait_tick("t5_rise", RISE, 11);
    step(1);
    ext = 1'b1;
    h0 = n_himid;
    wait_tick("t5_sync_fall", FALL, 3);
    check("t5_oe", scl_oe, 1);
    ext = 1'b0;
    wait_tick("t5_full_low", RISE, 11);
    step(1);
    check("t5_no_himid", n_himid - h0, 0);
    div_lo = 16'd2;
    div_hi = 16'd1;
    wait_tick("t6_fall", FALL, 7);
    wait_tick("t6_rise", RISE, 7);
    wait_tick("t6_hi_mid", HI_MID, 2);
    wait_tick("t6_fall2", FALL, 2);
    step(2);
    rst = 1'b1;
    step(1);
    check("t6_rst_oe", scl_oe, 0);
    check("t6_rst_busy", busy, 0);
    rst = 1'b0;
    en = 1'b0;
    step(2);
    check("one_tick_per_cycle", n_multi, 0);
    check("total_timeouts", n_to, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
